reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Generates the ordered, glitch-free reset releases that feed the team's register stages. Input is one raw asynchronous active-low reset plus a synchronous software reset request. Output is one reset per downstream domain. Every output is:
- asserted asynchronously;
- deasserted synchronously, in fixed order, after a hold period;
- driven by exactly one process.

Downstream flops therefore see a single clean reset source and need no redundant or multiply-driven asynchronous controls.

## Interface
Parameters:
- SYNC_STAGES, 2: depth of the reset-release synchronizer chain (legal ≥2).
- HOLD_CYCLES, 16: cycles all domains stay in reset after the synchronized release (legal ≥1).
- GAP_CYCLES, 4: cycles between consecutive domain releases (legal ≥1).
- NUM_DOMAINS, 3: number of reset outputs (legal 1..8).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- sw_rst_req  in  1  synchronous soft-reset request, active-high, sampled each edge.
- dom_rst_n  out  NUM_DOMAINS  per-domain reset, active-low; bit 0 is released first.
- ready  out  1  high once every domain is released.
- seq_state  out  2  FSM state: 0=HOLD, 1=RELEASE, 2=DONE.

## Operation
- **Reset values.** rst low forces, immediately and with no clock needed:
  - synchronizer chain = 0;
  - dom_rst_n = all 0, ready = 0;
  - seq_state = HOLD, internal counter cnt = 0, domain index idx = 0.
- **Synchronizer.** Shifts in 1 while rst is high; its last stage is rst_sync.
- **HOLD state.**
  - While rst_sync = 0, cnt stays 0.
  - Each edge with rst_sync = 1 increments cnt.
  - At the edge where cnt == HOLD_CYCLES-1: dom_rst_n[0] ← 1, cnt ← 0, idx ← 1, go to RELEASE. If NUM_DOMAINS == 1, also ready ← 1 and go to DONE.
- **RELEASE state.**
  - cnt increments each edge.
  - At the edge where cnt == GAP_CYCLES-1: dom_rst_n[idx] ← 1, cnt ← 0, idx ← idx+1.
  - When the released bit is NUM_DOMAINS-1, ready ← 1 on that same edge and go to DONE.
- **DONE state.** Holds all outputs; cnt is frozen.
- **sw_rst_req = 1 at an edge (any state, rst_sync = 1).**
  - Action: dom_rst_n ← 0, ready ← 0, cnt ← 0, idx ← 0, state ← HOLD.
  - The synchronizer is unaffected.
  - A held request keeps cnt at 0.
  - Priority: the request wins over a release scheduled on the same edge.
- **Release order and monotonicity.** Releases are strictly monotonic: once released, a domain bit returns to 0 only via rst or sw_rst_req. dom_rst_n[i] never rises before dom_rst_n[i-1].
- **Counter width.** cnt is clog2(max(HOLD_CYCLES, GAP_CYCLES))+1 bits and never wraps.
- **Single driver.** Every output bit is a flop with rst as its only asynchronous control.

## Timing
- Edge numbering: edge n = n-th rising clk edge after rst goes high (setup met).
- Synchronized release: rst_sync = 1 after edge SYNC_STAGES.
- Domain release: dom_rst_n[i] rises after edge SYNC_STAGES + HOLD_CYCLES + i·GAP_CYCLES.
- Defaults: dom_rst_n[0] at edge 18, [1] at edge 22, [2] at edge 26, ready at edge 26.
- Soft reset: sw_rst_req sampled high at edge t gives:
  - dom_rst_n = 0 and ready = 0 after edge t (1-cycle latency);
  - dom_rst_n[0] rises after edge t+HOLD_CYCLES (no resynchronization delay).
- rst assertion: combinational-to-flop async clear, 0 cycles. Deassertion is never passed through without SYNC_STAGES edges of delay.
- seq_state updates on the same edge as the corresponding output change.

## Test plan
1. **Power-on, defaults.** Hold rst = 0 for 5 cycles, then release.
   - During reset: dom_rst_n = 3'b000, ready = 0, seq_state = 0.
   - After release: dom_rst_n = 3'b001 after edge 18, 3'b011 after edge 22, 3'b111 and ready = 1 after edge 26. No earlier transition.
2. **Soft reset in DONE.** Pulse sw_rst_req for 1 cycle at edge 40.
   - dom_rst_n = 0 and ready = 0 after edge 40.
   - 3'b001 after edge 56, 3'b111 after edge 64.
3. **Soft reset mid-RELEASE.** Assert sw_rst_req at edge 20 (domain 0 released, domain 1 pending).
   - All bits clear after edge 20; domain 0 re-released after edge 36.
   - Separately, assert it on the exact edge scheduled for a release (edge 22): no release occurs; all bits read 0.
4. **Async rst mid-sequence.** Drop rst between edges 23 and 24.
   - Outputs clear before edge 24, with no clock edge required.
   - After re-release, full default timing from test 1 repeats.
5. **Glitch on rst.** Apply a rst low pulse shorter than a clock period while in DONE.
   - Outputs clear immediately.
   - Recovery needs SYNC_STAGES + HOLD_CYCLES edges before dom_rst_n[0] rises.
6. **Parameter corners.** Use NUM_DOMAINS = 1, HOLD_CYCLES = 1, GAP_CYCLES = 1, SYNC_STAGES = 3.
   - dom_rst_n[0] and ready both rise after edge 4.
   - A held sw_rst_req keeps dom_rst_n = 0 indefinitely.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// Reset sequencer bundle: soft-reset request in, ordered per-domain resets and status out.
interface reset_sequencer_if #(
    parameter int NUM_DOMAINS = 3
);
    logic                   sw_rst_req;
    logic [NUM_DOMAINS-1:0] dom_rst_n;
    logic                   ready;
    logic [1:0]             seq_state;

    modport master (
        input  sw_rst_req,
        output dom_rst_n,
        output ready,
        output seq_state
    );

    modport slave (
        output sw_rst_req,
        input  dom_rst_n,
        input  ready,
        input  seq_state
    );
endinterface

// File: rtl/reset_sequencer.sv
// Ordered reset release: async assert, synchronized deassert, then domains freed one by one
// after a hold period with a fixed gap. Every output is a flop cleared only by rst.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int NUM_DOMAINS = 3
) (
    input  logic              clk,
    input  logic              rst,
    reset_sequencer_if.master bus
);
    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam int IW      = $clog2(NUM_DOMAINS) + 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rst_sync;

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic [IW-1:0]          r_idx, w_idx_nxt;
    logic [NUM_DOMAINS-1:0] r_dom_rst_n, w_dom_nxt;
    logic                   r_ready, w_ready_nxt;

    // Deassertion of rst only reaches the sequencer after SYNC_STAGES edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_rst_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_HOLD;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_dom_rst_n <= '0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_dom_rst_n <= w_dom_nxt;
            r_ready     <= w_ready_nxt;
        end
    end

    // A soft request outranks any release due on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_dom_nxt   = r_dom_rst_n;
        w_ready_nxt = r_ready;

        if (w_rst_sync) begin
            if (bus.sw_rst_req) begin
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_dom_nxt   = '0;
                w_ready_nxt = 1'b0;
            end else begin
                case (r_state)
                    S_HOLD: begin
                        if (r_cnt == HOLD_LAST) begin
                            w_dom_nxt[0] = 1'b1;
                            w_cnt_nxt    = '0;
                            w_idx_nxt    = IW'(1);
                            if (NUM_DOMAINS == 1) begin
                                w_ready_nxt = 1'b1;
                                w_state_nxt = S_DONE;
                            end else begin
                                w_state_nxt = S_RELEASE;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    S_RELEASE: begin
                        if (r_cnt == GAP_LAST) begin
                            for (int i = 0; i < NUM_DOMAINS; i++) begin
                                if (r_idx == IW'(i)) begin
                                    w_dom_nxt[i] = 1'b1;
                                end
                            end
                            w_cnt_nxt = '0;
                            w_idx_nxt = r_idx + 1'b1;
                            if (r_idx == LAST_IDX) begin
                                w_ready_nxt = 1'b1;
                                w_state_nxt = S_DONE;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                    end
                    default: begin
                        w_state_nxt = S_HOLD;
                    end
                endcase
            end
        end
    end

    assign bus.dom_rst_n = r_dom_rst_n;
    assign bus.ready     = r_ready;
    assign bus.seq_state = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboarded bench for reset_sequencer: expected output changes are queued by edge number
// when stimulus is driven, and every edge the DUT is compared against the current expectation.
module tb_reset_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic rst2;

    int checks   = 0;
    int failures = 0;
    int edgeNo   = 0;

    typedef struct {
        int         edgeAt;
        logic [2:0] dom;
        logic       rdy;
        logic [1:0] st;
    } exp_t;

    exp_t       expQ[$];
    logic [2:0] expDom;
    logic       expReady;
    logic [1:0] expState;

    reset_sequencer_if #(.NUM_DOMAINS(3)) bus();
    reset_sequencer_if #(.NUM_DOMAINS(1)) bus2();

    reset_sequencer #(
        .SYNC_STAGES(2), .HOLD_CYCLES(16), .GAP_CYCLES(4), .NUM_DOMAINS(3)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );

    reset_sequencer #(
        .SYNC_STAGES(3), .HOLD_CYCLES(1), .GAP_CYCLES(1), .NUM_DOMAINS(1)
    ) dut2 (
        .clk(clk), .rst(rst2), .bus(bus2.master)
    );

    always #5 clk = ~clk;

    task automatic pushExp(input int e, input logic [2:0] d, input logic r, input logic [1:0] s);
        exp_t item;
        item.edgeAt = e;
        item.dom    = d;
        item.rdy    = r;
        item.st     = s;
        expQ.push_back(item);
    endtask

    task automatic clearExp();
        expQ.delete();
        expDom   = 3'b000;
        expReady = 1'b0;
        expState = 2'd0;
    endtask

    // Advances one edge and retires any expectation scheduled for it; sampling is 1 after the edge.
    task automatic stepEdge();
        exp_t item;
        @(posedge clk);
        #1;
        edgeNo++;
        while (expQ.size() > 0 && expQ[0].edgeAt == edgeNo) begin
            item     = expQ.pop_front();
            expDom   = item.dom;
            expReady = item.rdy;
            expState = item.st;
        end
    endtask

    task automatic applyStimulus(input logic rstVal, input logic swVal);
        rst            = rstVal;
        bus.sw_rst_req = swVal;
    endtask

    // Releases rst and queues the default release timeline relative to edge 0.
    task automatic startSequence();
        applyStimulus(1'b1, 1'b0);
        edgeNo = 0;
        clearExp();
        pushExp(18, 3'b001, 1'b0, 2'd1);
        pushExp(22, 3'b011, 1'b0, 2'd1);
        pushExp(26, 3'b111, 1'b1, 2'd2);
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus.dom_rst_n, bus.ready, bus.seq_state} !== {3'b000, 1'b0, 2'd0}) begin
                failures++;
                $display("[TB] FAIL reset_hold cyc=%0d got dom=%b rdy=%b st=%0d want dom=000 rdy=0 st=0",
                         i, bus.dom_rst_n, bus.ready, bus.seq_state);
            end
        end
        startSequence();
        while (edgeNo < 39) begin
            stepEdge();
            checks++;
            if ({bus.dom_rst_n, bus.ready, bus.seq_state} !== {expDom, expReady, expState}) begin
                failures++;
                $display("[TB] FAIL power_on edge=%0d got dom=%b rdy=%b st=%0d want dom=%b rdy=%b st=%0d",
                         edgeNo, bus.dom_rst_n, bus.ready, bus.seq_state, expDom, expReady, expState);
            end
        end
    endtask

    task automatic test_soft_done();
        applyStimulus(1'b1, 1'b1);
        pushExp(40, 3'b000, 1'b0, 2'd0);
        pushExp(56, 3'b001, 1'b0, 2'd1);
        pushExp(60, 3'b011, 1'b0, 2'd1);
        pushExp(64, 3'b111, 1'b1, 2'd2);
        stepEdge();
        applyStimulus(1'b1, 1'b0);
        checks++;
        if ({bus.dom_rst_n, bus.ready, bus.seq_state} !== {expDom, expReady, expState}) begin
            failures++;
            $display("[TB] FAIL soft_done_clear edge=%0d got dom=%b rdy=%b st=%0d want dom=%b rdy=%b st=%0d",
                     edgeNo, bus.dom_rst_n, bus.ready, bus.seq_state, expDom, expReady, expState);
        end
        while (edgeNo < 70) begin
            stepEdge();
            checks++;
            if ({bus.dom_rst_n, bus.ready, bus.seq_state} !== {expDom, expReady, expState}) begin
                failures++;
                $display("[TB] FAIL soft_done_recover edge=%0d got dom=%b rdy=%b st=%0d want dom=%b rdy=%b st=%0d",
                         edgeNo, bus.dom_rst_n, bus.ready, bus.seq_state, expDom, expReady, expState);
            end
        end
    endtask

    task automatic test_soft_release(input int reqEdge);
        applyStimulus(1'b0, 1'b0);
        #1;
        checks++;
        if ({bus.dom_rst_n, bus.ready, bus.seq_state} !== {3'b000, 1'b0, 2'd0}) begin
            failures++;
            $display("[TB] FAIL soft_rel_prereset got dom=%b rdy=%b st=%0d want dom=000 rdy=0 st=0",
                     bus.dom_rst_n, bus.ready, bus.seq_state);
        end
        @(posedge clk);
        #1;
        startSequence();
        while (edgeNo < reqEdge - 1) begin
            stepEdge();
            checks++;
            if ({bus.dom_rst_n, bus.ready, bus.seq_state} !== {expDom, expReady, expState}) begin
                failures++;
                $display("[TB] FAIL soft_rel_pre edge=%0d got dom=%b rdy=%b st=%0d want dom=%b rdy=%b st=%0d",
                         edgeNo, bus.dom_rst_n, bus.ready, bus.seq_state, expDom, expReady, expState);
            end
        end
        applyStimulus(1'b1, 1'b1);
        expQ.delete();
        pushExp(reqEdge,      3'b000, 1'b0, 2'd0);
        pushExp(reqEdge + 16, 3'b001, 1'b0, 2'd1);
        pushExp(reqEdge + 20, 3'b011, 1'b0, 2'd1);
        pushExp(reqEdge + 24, 3'b111, 1'b1, 2'd2);
        stepEdge();
        applyStimulus(1'b1, 1'b0);
        checks++;
        if ({bus.dom_rst_n, bus.ready, bus.seq_state} !== {expDom, expReady, expState}) begin
            failures++;
            $display("[TB] FAIL soft_rel_clear edge=%0d got dom=%b rdy=%b st=%0d want dom=%b rdy=%b st=%0d",
                     edgeNo, bus.dom_rst_n, bus.ready, bus.seq_state, expDom, expReady, expState);
        end
        while (edgeNo < reqEdge + 26) begin
            stepEdge();
            checks++;
            if ({bus.dom_rst_n, bus.ready, bus.seq_state} !== {expDom, expReady, expState}) begin
                failures++;
                $display("[TB] FAIL soft_rel_recover edge=%0d got dom=%b rdy=%b st=%0d want dom=%b rdy=%b st=%0d",
                         edgeNo, bus.dom_rst_n, bus.ready, bus.seq_state, expDom, expReady, expState);
            end
        end
    endtask

    task automatic test_async_mid();
        applyStimulus(1'b0, 1'b0);
        @(posedge clk);
        #1;
        startSequence();
        while (edgeNo < 23) begin
            stepEdge();
            checks++;
            if ({bus.dom_rst_n, bus.ready, bus.seq_state} !== {expDom, expReady, expState}) begin
                failures++;
                $display("[TB] FAIL async_pre edge=%0d got dom=%b rdy=%b st=%0d want dom=%b rdy=%b st=%0d",
                         edgeNo, bus.dom_rst_n, bus.ready, bus.seq_state, expDom, expReady, expState);
            end
        end
        #2;
        applyStimulus(1'b0, 1'b0);
        clearExp();
        #1;
        checks++;
        if ({bus.dom_rst_n, bus.ready, bus.seq_state} !== {expDom, expReady, expState}) begin
            failures++;
            $display("[TB] FAIL async_clear got dom=%b rdy=%b st=%0d want dom=%b rdy=%b st=%0d",
                     bus.dom_rst_n, bus.ready, bus.seq_state, expDom, expReady, expState);
        end
        @(posedge clk);
        #1;
        startSequence();
        while (edgeNo < 30) begin
            stepEdge();
            checks++;
            if ({bus.dom_rst_n, bus.ready, bus.seq_state} !== {expDom, expReady, expState}) begin
                failures++;
                $display("[TB] FAIL async_recover edge=%0d got dom=%b rdy=%b st=%0d want dom=%b rdy=%b st=%0d",
                         edgeNo, bus.dom_rst_n, bus.ready, bus.seq_state, expDom, expReady, expState);
            end
        end
    endtask

    task automatic test_glitch();
        #2;
        applyStimulus(1'b0, 1'b0);
        #1;
        checks++;
        if ({bus.dom_rst_n, bus.ready, bus.seq_state} !== {3'b000, 1'b0, 2'd0}) begin
            failures++;
            $display("[TB] FAIL glitch_clear got dom=%b rdy=%b st=%0d want dom=000 rdy=0 st=0",
                     bus.dom_rst_n, bus.ready, bus.seq_state);
        end
        #1;
        startSequence();
        while (edgeNo < 28) begin
            stepEdge();
            checks++;
            if ({bus.dom_rst_n, bus.ready, bus.seq_state} !== {expDom, expReady, expState}) begin
                failures++;
                $display("[TB] FAIL glitch_recover edge=%0d got dom=%b rdy=%b st=%0d want dom=%b rdy=%b st=%0d",
                         edgeNo, bus.dom_rst_n, bus.ready, bus.seq_state, expDom, expReady, expState);
            end
        end
    endtask

    task automatic test_corner();
        bus2.sw_rst_req = 1'b0;
        rst2            = 1'b1;
        edgeNo          = 0;
        clearExp();
        pushExp(4, 3'b001, 1'b1, 2'd2);
        while (edgeNo < 8) begin
            stepEdge();
            checks++;
            if ({bus2.dom_rst_n, bus2.ready, bus2.seq_state} !== {expDom[0], expReady, expState}) begin
                failures++;
                $display("[TB] FAIL corner_release edge=%0d got dom=%b rdy=%b st=%0d want dom=%b rdy=%b st=%0d",
                         edgeNo, bus2.dom_rst_n, bus2.ready, bus2.seq_state, expDom[0], expReady, expState);
            end
        end
        bus2.sw_rst_req = 1'b1;
        pushExp(9, 3'b000, 1'b0, 2'd0);
        while (edgeNo < 28) begin
            stepEdge();
            checks++;
            if ({bus2.dom_rst_n, bus2.ready, bus2.seq_state} !== {expDom[0], expReady, expState}) begin
                failures++;
                $display("[TB] FAIL corner_held edge=%0d got dom=%b rdy=%b st=%0d want dom=%b rdy=%b st=%0d",
                         edgeNo, bus2.dom_rst_n, bus2.ready, bus2.seq_state, expDom[0], expReady, expState);
            end
        end
        bus2.sw_rst_req = 1'b0;
        pushExp(29, 3'b001, 1'b1, 2'd2);
        while (edgeNo < 32) begin
            stepEdge();
            checks++;
            if ({bus2.dom_rst_n, bus2.ready, bus2.seq_state} !== {expDom[0], expReady, expState}) begin
                failures++;
                $display("[TB] FAIL corner_recover edge=%0d got dom=%b rdy=%b st=%0d want dom=%b rdy=%b st=%0d",
                         edgeNo, bus2.dom_rst_n, bus2.ready, bus2.seq_state, expDom[0], expReady, expState);
            end
        end
    endtask

    initial begin
        rst2            = 1'b0;
        bus2.sw_rst_req = 1'b0;
        clearExp();
        applyStimulus(1'b0, 1'b0);
        $display("[TB] starting reset_sequencer bench");
        test_reset();
        test_soft_done();
        test_soft_release(20);
        test_soft_release(22);
        test_async_mid();
        test_glitch();
        test_corner();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
